// File: rtl/uart_baud_pkg.sv
// Shared types and defaults for the UART baud-rate controller.
package uart_baud_pkg;

  typedef enum logic [1:0] {RUN, PEND, LOAD} baud_state_e;

  localparam int OVS_DEFAULT       = 16;
  localparam int DEFAULT_DIV_19200 = 163;

endpackage

// File: rtl/baud_tick_gen.sv
// Loadable mod-div counter: counts 0..div-1, pulses sample_tick on the last count.
// clr restarts the phase at 0; suppress masks the tick for that cycle.
module baud_tick_gen #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] div,
  input  logic         clr,
  input  logic         suppress,
  output logic [N-1:0] cnt_q,
  output logic         sample_tick
);

  logic wrap;

  // div is never 0 (clamped upstream), so div-1 cannot underflow.
  assign wrap        = (cnt_q == div - N'(1));
  assign sample_tick = wrap && !suppress;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (wrap) cnt_q <= '0;
    else           cnt_q <= cnt_q + N'(1);
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Run-time baud controller: defers divisor updates until TX/RX are idle, then reloads phase.
// Optional UART_BAUD_TIMEOUT_EN adds a bit_tick watchdog that forces the load.
module uart_baud_ctrl
  import uart_baud_pkg::*;
#(
  parameter int N            = 8,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_19200,
  parameter int OVS          = OVS_DEFAULT,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [N-1:0] cfg_div,
  output logic         cfg_ready,
  input  logic         tx_busy,
  input  logic         rx_busy,
  output logic         sample_tick,
  output logic         bit_tick,
  output logic [N-1:0] div_q,
  output logic [N-1:0] cnt_q,
  output logic         cfg_pending,
  output logic         cfg_forced
);

  localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;

  baud_state_e   state_q, state_d;
  logic [N-1:0]  pend_q;
  logic [OW-1:0] ovs_q;
  logic          load;
  logic          timeout;

  baud_tick_gen #(.N(N)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .div         (div_q),
    .clr         (load),
    .suppress    (load),
    .cnt_q       (cnt_q),
    .sample_tick (sample_tick)
  );

  assign bit_tick = sample_tick && (ovs_q == OW'(OVS - 1));

`ifdef UART_BAUD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_BITS + 1);
  logic [WW-1:0] wdog_q;
  logic          forced_q;

  assign timeout    = (wdog_q == WW'(TIMEOUT_BITS));
  assign cfg_forced = (state_q == LOAD) && forced_q;

  // Watchdog is held at 0 outside PEND, so it starts clean on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      forced_q <= (state_q == PEND) && timeout && (tx_busy || rx_busy);
      if (state_q != PEND)          wdog_q <= '0;
      else if (bit_tick && !timeout) wdog_q <= wdog_q + WW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_BITS != 0);
  assign timeout        = 1'b0;
  assign cfg_forced     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_valid) state_d = PEND;
      PEND:    if ((!tx_busy && !rx_busy) || timeout) state_d = LOAD;
      LOAD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cfg_ready   = (state_q == RUN);
    cfg_pending = (state_q == PEND);
    load        = (state_q == LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      div_q  <= N'(DEFAULT_DIV);
      ovs_q  <= '0;
    end else begin
      if (cfg_ready && cfg_valid)
        pend_q <= (cfg_div == '0) ? N'(1) : cfg_div;
      if (load) begin
        div_q <= pend_q;
        ovs_q <= '0;
      end else if (sample_tick) begin
        ovs_q <= (ovs_q == OW'(OVS - 1)) ? '0 : ovs_q + OW'(1);
      end
    end
  end

endmodule
